data_mem_pipe: RTL

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_fmt.sv | 46 ++++
 rtl/data_mem_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data memory: access-type encoding, FSM states and lane count.
package dmem_pkg;

  localparam int BE_W = 4;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane formatter: store byte-enables and replicated write data,
// load byte/halfword extraction with sign or zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [31:0]     wdata,
  input  logic [31:0]     rword,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata_sh,
  output logic [31:0]     rdata
);

  logic [15:0] rsh;

  // lane is already aligned for halfwords, so a byte shift serves both widths
  assign rsh = 16'(rword >> {lane, 3'b000});

  always_comb begin
    be       = '0;
    wdata_sh = '0;
    rdata    = '0;
    case (funct3)
      F3_B: begin
        be       = BE_W'(1) << lane;
        wdata_sh = {4{wdata[7:0]}};
        rdata    = {{24{rsh[7]}}, rsh[7:0]};
      end
      F3_H: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        rdata    = {{16{rsh[15]}}, rsh[15:0]};
      end
      F3_W: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        rdata    = rword;
      end
      F3_BU:   rdata = {24'b0, rsh[7:0]};
      F3_HU:   rdata = {16'b0, rsh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Single-outstanding data memory with byte-lane stores and READ_LAT-cycle loads.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W instead of force-aligning them.
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          READ_LAT  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

  state_e          state;
  logic [1:0]      cnt;
  logic [31:0]     word_off;
  logic [IDX_W-1:0] idx;
  logic            in_range, type_ok, is_h, is_w, fault, accept, wr_en;
  logic [1:0]      lane;
  logic [BE_W-1:0] be;
  logic [31:0]     wdata_sh, rword, ld_data;
  logic [31:0]     mem [DEPTH];

  // addresses below BASE_ADDR wrap to a huge offset, but are rejected explicitly anyway
  assign word_off = (req_addr - BASE_ADDR) >> 2;
  assign in_range = (req_addr >= BASE_ADDR) && (word_off < 32'(DEPTH));
  assign idx      = word_off[IDX_W-1:0];

  always_comb begin
    type_ok = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: type_ok = 1'b1;
      F3_BU, F3_HU:     type_ok = !req_we;
      default:          type_ok = 1'b0;
    endcase
  end

  assign is_h = (req_funct3[1:0] == 2'b01);
  assign is_w = (req_funct3 == F3_W);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
  assign fault      = !in_range || !type_ok || misaligned;
  assign lane       = req_addr[1:0];
`else
  assign fault = !in_range || !type_ok;
  assign lane  = is_w ? 2'b00 : (is_h ? {req_addr[1], 1'b0} : req_addr[1:0]);
`endif

  dmem_lane_fmt u_lane_fmt (
    .funct3   (req_funct3),
    .lane     (lane),
    .wdata    (req_wdata),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (ld_data)
  );

  assign accept = req_valid && req_ready;
  assign wr_en  = accept && req_we && !fault && rst_n;
  assign rword  = mem[idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Response data is captured at accept; RD_WAIT only delays its presentation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_err   <= fault;
            rsp_rdata <= (req_we || fault) ? 32'd0 : ld_data;
            if (req_we || READ_LAT == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= RD_WAIT;
              cnt   <= 2'd1;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == LAST_CNT) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            cnt       <= 2'd0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 2'd0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
